// File: rtl/alu_div_sequencer_if.sv
// Bundle between the execute stage, the shared ALU and the divide sequencer.
// master = pipeline/ALU side, slave = the sequencer.
interface alu_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic             alu_unsign;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;

  modport master (
    output start, op, dividend, divisor, alu_out, alu_cout,
    input  busy, done, result, alu_a, alu_b, alu_ctrl, alu_unsign
  );

  modport slave (
    input  start, op, dividend, divisor, alu_out, alu_cout,
    output busy, done, result, alu_a, alu_b, alu_ctrl, alu_unsign
  );
endinterface

// File: rtl/alu_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU by restoring division, borrowing the shared ALU's
// SUB for one trial subtract per cycle; special cases resolve without iterating.
module alu_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                clk,
  input logic                reset,
  alu_div_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic             rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] shift_s;
  logic             shift_c;
  logic             take;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // The ALU answers combinationally, so the trial subtract is consumed in the same cycle.
  assign shift_c = r_q[WIDTH-1];
  assign shift_s = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign take    = shift_c | bus.alu_cout;
  assign q_fix   = neg_quot_q ? -q_q : q_q;
  assign r_fix   = neg_rem_q  ? -r_q : r_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sgn_d      = sgn_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    count_d    = count_q;
    done_d     = 1'b0;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        // busy_q still covers the done cycle, so a start there is ignored.
        if (bus.start && !busy_q) begin
          rem_d = bus.op[1];
          sgn_d = ~bus.op[0];
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          if (bus.divisor == '0) begin
            q_d      = '1;
            r_d      = bus.dividend;
            result_d = bus.op[1] ? bus.dividend : '1;
            state_d  = S_DONE;
          end else if (!bus.op[0] && bus.dividend == MIN_NEG && bus.divisor == '1) begin
            q_d      = bus.dividend;
            r_d      = '0;
            result_d = bus.op[1] ? '0 : bus.dividend;
            state_d  = S_DONE;
          end else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        q_d        = (sgn_q && q_q[WIDTH-1]) ? -q_q : q_q;
        d_d        = (sgn_q && d_q[WIDTH-1]) ? -d_q : d_q;
        r_d        = '0;
        count_d    = '0;
        neg_quot_d = sgn_q & (q_q[WIDTH-1] ^ d_q[WIDTH-1]);
        neg_rem_d  = sgn_q & q_q[WIDTH-1];
        state_d    = S_ITER;
      end
      S_ITER: begin
        r_d     = take ? bus.alu_out : shift_s;
        q_d     = {q_q[WIDTH-2:0], take};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        q_d      = q_fix;
        r_d      = r_fix;
        result_d = rem_q ? r_fix : q_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_q      <= 1'b0;
      sgn_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sgn_q      <= sgn_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign bus.alu_a      = (state_q == S_ITER) ? shift_s : '0;
  assign bus.alu_b      = (state_q == S_ITER) ? d_q : '0;
  assign bus.alu_ctrl   = (state_q == S_ITER) ? 4'b0001 : 4'b0000;
  assign bus.alu_unsign = 1'b1;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Randomized and directed bench for alu_div_sequencer with a queue-based scoreboard
// and a plain-arithmetic RV32M reference model; the bench also plays the ALU.
module tb_alu_div_sequencer;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
  localparam logic [W-1:0] ALL1    = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_div_sequencer_if #(.WIDTH(W)) bus ();

  alu_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Shared ALU: SUB yields a + ~b + 1, whose carry means a >= b unsigned.
  logic [W:0] alu_sum;
  always_comb begin
    if (bus.alu_ctrl == 4'b0001) alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
    else                         alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  end
  assign bus.alu_out  = alu_sum[W-1:0];
  assign bus.alu_cout = alu_sum[W];

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           subs;
    int           start_cyc;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (b == '0) return op[1] ? a : ALL1;
    if (!op[0]) begin
      if (a == MIN_NEG && b == ALL1) return op[1] ? '0 : a;
      return op[1] ? W'(sa % sb) : W'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (!op[0] && a == MIN_NEG && b == ALL1);
  endfunction

  // Monitor: pops the oldest expectation whenever done is seen.
  int sub_cnt = 0;
  int busy_err = 0;
  int unsign_err = 0;
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      sub_cnt    = 0;
      busy_err   = 0;
      unsign_err = 0;
      if (bus.done === 1'b1) begin
        n_checks++;
        $display("[TB] FAIL unexpected_done: got done=1, expected done=0 at cycle %0d", cyc);
      end
    end else begin
      if (bus.alu_ctrl === 4'b0001) sub_cnt++;
      if (cyc > exp_q[0].start_cyc && bus.busy !== 1'b1) busy_err++;
      if (bus.alu_unsign !== 1'b1) unsign_err++;
      if (bus.done === 1'b1) begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_result"}, bus.result, e.res);
        checkOutput({e.name, "_latency"}, W'(cyc - e.start_cyc), W'(e.lat));
        checkOutput({e.name, "_sub_cycles"}, W'(sub_cnt), W'(e.subs));
        checkOutput({e.name, "_busy_low_cycles"}, W'(busy_err), '0);
        checkOutput({e.name, "_unsign_low_cycles"}, W'(unsign_err), '0);
        sub_cnt    = 0;
        busy_err   = 0;
        unsign_err = 0;
      end
    end
  end

  // Issues one request; expected = explicit constant when use_exp, else the model.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit use_exp, input logic [W-1:0] exp_res);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    e.res       = use_exp ? exp_res : ref_model(op, a, b);
    e.lat       = is_fast(op, a, b) ? 2 : W + 4;
    e.subs      = is_fast(op, a, b) ? 0 : W;
    e.start_cyc = cyc;
    e.name      = name;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic waitDone();
    int t = 0;
    while (bus.done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("[TB] FAIL done_timeout: got no done within 100 cycles, expected done");
      exp_q.delete();
    end
  endtask

  task automatic runOne(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit use_exp, input logic [W-1:0] exp_res);
    applyStimulus(name, op, a, b, use_exp, exp_res);
    waitDone();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           sel;

    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, bus.busy}, '0);
    checkOutput("reset_done", {31'd0, bus.done}, '0);
    checkOutput("reset_result", bus.result, '0);
    checkOutput("reset_alu_a", bus.alu_a, '0);
    checkOutput("reset_alu_ctrl", {28'd0, bus.alu_ctrl}, '0);
    reset = 1'b0;

    runOne("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b1, 32'd14);
    runOne("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b1, 32'd2);
    runOne("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
    runOne("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
    runOne("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1);
    runOne("divu_by_zero", 2'b01, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
    runOne("rem_by_zero", 2'b10, 32'h8000_0000, 32'd0, 1'b1, 32'h8000_0000);
    runOne("div_overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    runOne("rem_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
    runOne("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'd1);
    runOne("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFE);

    // A second start mid-iteration must not disturb the operation in flight.
    applyStimulus("divu_ignored_start", 2'b01, 32'd1000, 32'd3, 1'b1, 32'd333);
    repeat (10) @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 2'b11;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone();

    // Reset around iteration 10 abandons the operation; no done may follow.
    applyStimulus("div_aborted", 2'b00, 32'd12345, 32'hFFFF_FFEF, 1'b0, '0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, bus.busy}, '0);
    checkOutput("abort_done", {31'd0, bus.done}, '0);
    checkOutput("abort_result", bus.result, '0);
    checkOutput("abort_alu_b", bus.alu_b, '0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    runOne("divu_after_abort", 2'b01, 32'd77, 32'd7, 1'b1, 32'd11);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      sel = $urandom_range(0, 15);
      if (sel < 2)       rb = '0;
      else if (sel < 5)  rb = W'($urandom_range(1, 20));
      else if (sel == 5) begin
        ra = MIN_NEG;
        rb = ALL1;
      end else if (sel < 9) rb = ALL1 - W'($urandom_range(0, 9));
      else               rb = $urandom >> $urandom_range(0, 30);
      if (rb == '0 && sel >= 2) rb = 32'd1;
      runOne($sformatf("rand%0d", i), rop, ra, rb, 1'b0, '0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
